// File: rtl/dram_resp.sv
// dram_resp: LSU data-RAM responder with a one-entry posted write buffer, write combining and read forwarding
module dram_resp #(
  parameter int DRAM_AW    = 64,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DRAM_AW-1:0] i_dram_addr,
  input  logic [7:0]         i_dram_we,
  input  logic               i_dram_re,
  input  logic [63:0]        i_dram_din,
  output logic [63:0]        o_dram_dout,
  output logic               o_dram_err,
  output logic               o_pwb_valid
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [63:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] idx, pwb_idx_q, pwb_idx_d;
  logic [7:0] pwb_be_q, pwb_be_d;
  logic [63:0] pwb_data_q, pwb_data_d, dout_q, dout_d, rdata, fwd;
  logic pwb_valid_q, pwb_valid_d, err_q, err_d;
  logic in_rng, wr, rd, hit, combine, drain, unused_addr;
  assign unused_addr = ^i_dram_addr[2:0];
  // decode the request and build the forwarded read word
  always_comb begin
    idx = i_dram_addr[3 +: DEPTH_LOG2];
    in_rng = i_dram_addr[DRAM_AW-1:3+DEPTH_LOG2] == '0;
    wr = |i_dram_we;
    rd = i_dram_re & ~wr;
    hit = pwb_valid_q & (pwb_idx_q == idx);
    combine = wr & in_rng & hit;
    drain = pwb_valid_q & ~rd & ~combine;
    rdata = mem_q[idx];
    fwd = rdata;
    for (int k = 0; k < 8; k++)
      fwd[8*k +: 8] = (hit & pwb_be_q[k]) ? pwb_data_q[8*k +: 8] : rdata[8*k +: 8];
  end
  // next state of the write buffer, read data and sticky error
  always_comb begin
    pwb_idx_d = pwb_idx_q;
    pwb_be_d = pwb_be_q;
    pwb_data_d = pwb_data_q;
    pwb_valid_d = pwb_valid_q & ~drain;
    err_d = err_q | ((wr | rd) & ~in_rng);
    dout_d = rd ? (in_rng ? fwd : '0) : dout_q;
    if (wr & in_rng) begin
      pwb_valid_d = 1'b1;
      pwb_idx_d = idx;
      pwb_be_d = combine ? (pwb_be_q | i_dram_we) : i_dram_we;
      for (int k = 0; k < 8; k++)
        pwb_data_d[8*k +: 8] = (i_dram_we[k] | ~combine) ? i_dram_din[8*k +: 8] : pwb_data_q[8*k +: 8];
    end
  end
  // array write port: byte-masked drain of the buffered word when the port is free
  always_ff @(posedge clk) begin
    if (drain)
      for (int k = 0; k < 8; k++)
        if (pwb_be_q[k]) mem_q[pwb_idx_q][8*k +: 8] <= pwb_data_q[8*k +: 8];
  end
  // state registers; buffer contents are dropped on reset, the array is not
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwb_idx_q <= '0;
      pwb_be_q <= '0;
      pwb_data_q <= '0;
      pwb_valid_q <= 1'b0;
      dout_q <= '0;
      err_q <= 1'b0;
    end else begin
      pwb_idx_q <= pwb_idx_d;
      pwb_be_q <= pwb_be_d;
      pwb_data_q <= pwb_data_d;
      pwb_valid_q <= pwb_valid_d;
      dout_q <= dout_d;
      err_q <= err_d;
    end
  end
  assign o_dram_dout = dout_q;
  assign o_dram_err = err_q;
  assign o_pwb_valid = pwb_valid_q;
endmodule

// File: tb/tb_dram_resp.sv
// tb_dram_resp: random and directed checks of dram_resp against a flat-memory reference model
module tb_dram_resp;
  logic clk = 1'b0, rst = 1'b1, re = 1'b0, err, pv;
  logic [63:0] addr = '0, din = '0, dout;
  logic [7:0] we = '0;
  int checks = 0, errors = 0;
  bit [63:0] m [longint];
  bit [63:0] e_dout = '0;
  bit e_err = 1'b0, e_pv = 1'b0;
  dram_resp dut (
    .clk(clk), .rst(rst), .i_dram_addr(addr), .i_dram_we(we), .i_dram_re(re),
    .i_dram_din(din), .o_dram_dout(dout), .o_dram_err(err), .o_pwb_valid(pv)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic step(input string t, input logic [63:0] a, input logic [7:0] w, input logic r, input logic [63:0] d);
    longint i;
    bit inr, wr, rd;
    bit [63:0] tmp;
    addr = a; we = w; re = r; din = d;
    @(posedge clk);
    #1;
    i = longint'(a[14:3]);
    inr = (a >> 15) == 0;
    wr = w != 0;
    rd = r && !wr;
    if ((wr || rd) && !inr) e_err = 1'b1;
    if (rd) e_dout = inr ? (m.exists(i) ? m[i] : 64'h0) : 64'h0;
    if (wr && inr) begin
      tmp = m.exists(i) ? m[i] : 64'h0;
      for (int k = 0; k < 8; k++) if (w[k]) tmp[8*k +: 8] = d[8*k +: 8];
      m[i] = tmp;
      e_pv = 1'b1;
    end else if (!rd) e_pv = 1'b0;
    chk({t, ".dout"}, dout, e_dout);
    chk({t, ".err"}, {63'b0, err}, {63'b0, e_err});
    chk({t, ".pwb_valid"}, {63'b0, pv}, {63'b0, e_pv});
  endtask
  initial begin
    logic [63:0] a;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.dout", dout, 64'h0);
    chk("rst.err", {63'b0, err}, 64'h0);
    chk("rst.pwb_valid", {63'b0, pv}, 64'h0);
    @(negedge clk) rst = 1'b0;
    step("wr40", 64'h40, 8'hFF, 1'b0, 64'h1122334455667788);
    step("idle", 64'h0, 8'h00, 1'b0, 64'h0);
    step("rd40", 64'h40, 8'h00, 1'b1, 64'h0);
    chk("rd40.value", dout, 64'h1122334455667788);
    for (int j = 0; j < 8; j++) step("pre", 64'(j * 8), 8'hFF, 1'b0, 64'h0);
    step("pre80", 64'h80, 8'hFF, 1'b0, 64'h0);
    step("idle", 64'h0, 8'h00, 1'b0, 64'h0);
    step("cmbA", 64'h80, 8'h01, 1'b0, {8{8'hAA}});
    step("cmbB", 64'h80, 8'h80, 1'b0, {8{8'hBB}});
    step("cmbR", 64'h80, 8'h00, 1'b1, 64'h0);
    chk("cmb.value", dout, 64'hBB000000000000AA);
    chk("cmb.pwb_held", {63'b0, pv}, 64'h1);
    step("idle", 64'h0, 8'h00, 1'b0, 64'h0);
    step("b2b0", 64'h00, 8'h0F, 1'b0, 64'h00000000DEADBEEF);
    step("b2b8", 64'h08, 8'hF0, 1'b0, 64'hDEADBEEF00000000);
    step("b2bR0", 64'h00, 8'h00, 1'b1, 64'h0);
    chk("b2b0.value", dout, 64'h00000000DEADBEEF);
    step("b2bR8", 64'h08, 8'h00, 1'b1, 64'h0);
    chk("b2b8.value", dout, 64'hDEADBEEF00000000);
    step("rewe", 64'h10, 8'hFF, 1'b1, 64'h0123456789ABCDEF);
    chk("rewe.hold", dout, 64'hDEADBEEF00000000);
    step("rd10", 64'h10, 8'h00, 1'b1, 64'h0);
    chk("rd10.value", dout, 64'h0123456789ABCDEF);
    step("oorR", 64'h1 << 15, 8'h00, 1'b1, 64'h0);
    chk("oor.dout", dout, 64'h0);
    chk("oor.err", {63'b0, err}, 64'h1);
    step("oorW", (64'h1 << 20) | 64'h40, 8'hFF, 1'b0, 64'hFFFF);
    step("legal", 64'h40, 8'h00, 1'b1, 64'h0);
    chk("oor.sticky", {63'b0, err}, 64'h1);
    chk("oorW.noupd", dout, 64'h1122334455667788);
    for (int n = 0; n < 600; n++) begin
      a = ($urandom_range(0, 5) == 5) ? 64'h40 : 64'($urandom_range(0, 4) * 8);
      if ($urandom_range(0, 15) == 0) a = a | (64'h1 << (15 + $urandom_range(0, 48)));
      step("rand", a, ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom), 1'($urandom), {$urandom, $urandom});
    end
    step("preR", 64'h40, 8'h00, 1'b1, 64'h0);
    step("preE", 64'h1 << 40, 8'h00, 1'b1, 64'h0);
    step("preW", 64'h7F8, 8'hFF, 1'b0, 64'hCAFEF00DCAFEF00D);
    #2 rst = 1'b1;
    #1;
    chk("arst.dout", dout, 64'h0);
    chk("arst.err", {63'b0, err}, 64'h0);
    chk("arst.pwb_valid", {63'b0, pv}, 64'h0);
    m.delete(255);
    e_dout = '0; e_err = 1'b0; e_pv = 1'b0;
    @(negedge clk) rst = 1'b0;
    step("post", 64'h40, 8'h00, 1'b1, 64'h0);
    step("post", 64'h00, 8'h00, 1'b1, 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dram_resp.md
Name: dram_resp

Overview:
- Memory-side responder for the LSU data-RAM interface.
- Accepts the 8-byte-aligned address, byte write enables, read strobe and replicated store data that the LSU drives, and returns registered 64-bit read data.
- Holds a single-port word array behind a one-entry posted write buffer. The buffer provides write combining and read forwarding.
- Sits between the LSU and the simulation data memory in the cpu_diff top level.

Parameters:
- DRAM_AW, 64, byte-address width of the interface.
- DEPTH_LOG2, 12, log2 of the number of 64-bit words in the array.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_dram_addr  input  DRAM_AW  byte address; bits [2:0] ignored (always 000 from LSU).
- i_dram_we  input  8  byte write enables; bit k writes byte lane k = din[8k+7:8k].
- i_dram_re  input  1  read strobe.
- i_dram_din  input  64  store data, already lane-replicated.
- o_dram_dout  output  64  registered read data.
- o_dram_err  output  1  sticky out-of-range access flag.
- o_pwb_valid  output  1  posted write buffer holds undrained data (verification visibility).

Behaviour:
- Clock/reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - o_dram_dout = 0, o_dram_err = 0, o_pwb_valid = 0.
  - Buffer index, byte-enable and data registers = 0.
  - Array contents are not reset.
- Decode:
  - idx = addr[3+DEPTH_LOG2-1:3].
  - The access is in range iff addr[DRAM_AW-1:3+DEPTH_LOG2] == 0.
- Request qualification:
  - wr = (we != 0).
  - rd = re & ~wr. Write wins; a simultaneous re is ignored and dout holds.
- Out-of-range access (wr or rd):
  - No array or buffer update.
  - o_dram_err set at the next edge and held until reset.
  - An out-of-range read loads dout = 0 next cycle.
- Read latency is 1 cycle:
  - rd in cycle N gives o_dram_dout valid from cycle N+1 until the next rd.
  - Without rd, dout holds.
- Read forwarding: if pwb valid and pwb_idx == idx, dout = per-byte mux. Lanes with pwb_be[k] set take pwb_data; other lanes take array[idx]. Otherwise dout = array[idx].
- Array port is single port; a read has priority.
- Drain: pwb drains (array[pwb_idx] bytes under pwb_be <= pwb_data; pwb_valid <= 0) on any cycle with pwb valid and no rd. The exception is a combining write (below).
- Write with pwb empty: capture idx, we, din into pwb; pwb_valid <= 1.
- Write with pwb valid and same idx (combine):
  - pwb_be <= pwb_be | we.
  - Per lane, new data where we[k], else old data.
  - No drain this cycle.
- Write with pwb valid and different idx: the old entry drains this cycle (legal, since no rd), and the new write is captured in the same edge.
- Read followed immediately by a write to the same word: the read returns pre-write data. A read in the cycle after a write sees the write through forwarding.
- Reset mid-operation: undrained pwb content is lost; the array keeps previously drained words.
- Combinational paths: none from inputs to outputs. All outputs are registered.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> dout = 0, err = 0, pwb_valid = 0 immediately, without waiting for a clk edge.
- Write/read-back:
  - Write we=FF, din=0x1122334455667788 at addr 0x40, idle 1 cycle (drain), then read 0x40 -> dout = 0x1122334455667788 one cycle after re.
  - o_pwb_valid pulses 1 for exactly one cycle.
- Byte combine and forward:
  - Preload word 0x80 = 0.
  - Write we=01, din=replicated 0xAA; next cycle write we=80, din=replicated 0xBB, same address; next cycle read.
  - Expected dout = 0xBB000000000000AA with pwb_valid still 1 (no drain while read occupies the port).
- Back-to-back different words:
  - Write 0x00 (we=0F, 0xDEADBEEF in low lanes), then write 0x08 (we=F0), then read 0x00 and 0x08.
  - Expected: first word drained at the second write, second word forwarded; dout = 0x00000000DEADBEEF, then 0xDEADBEEF00000000 in the upper lanes.
- Simultaneous re/we: we=FF, re=1 at 0x10 -> write captured, dout unchanged.
- Out of range: read addr 1<<(3+DEPTH_LOG2) -> dout = 0, err = 1, and err stays 1 after subsequent legal accesses until rst.
